i2c_reg_sequencer: RTL
======================

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, 9, number of 16-bit register words written per sequence (1..64).
REQ-002 SHALL have parameter CLK_DIV, 125, clk cycles per quarter SCL period (>=2; 125 gives 100 kHz SCL at 50 MHz).
REQ-003 SHALL have parameter DEV_ADDR, 7'h1A, 7-bit slave address; address byte sent = {DEV_ADDR,1'b0}.
REQ-004 SHALL have parameter AUTO_START, 1, when 1 a sequence starts automatically in the first cycle after reset deasserts.
REQ-005 SHALL have parameter MAX_RETRY, 3, retries per word on NACK (only used with I2C_ACK_CHECK_EN).
REQ-006 SHALL have port clk input 1, single system clock (50 MHz); all logic on its rising edge.
REQ-007 SHALL have port reset input 1, synchronous, active-high.
REQ-008 SHALL have port start input 1, single-cycle pulse requesting a full sequence.
REQ-009 SHALL have port cfg_table input NUM_REGS*16, word k = cfg_table[16k+15:16k] = {reg_addr[6:0], data[8:0]}, sampled per word at its byte-load.
REQ-010 SHALL have port i2c_data inout 1, SDA; driven 0 or released (z) only, never driven 1.
REQ-011 SHALL have port i2c_clk output 1, SCL, push-pull.
REQ-012 SHALL have ports busy output 1, done output 1, error output 1, err_index output 6 (index of failing word).

Function
REQ-013 Tick: internal divider SHALL pulse once every CLK_DIV clk cycles while busy; all line changes occur only on ticks; divider held at 0 when idle.
REQ-014 Each SCL bit SHALL span 4 ticks: SCL low on Q0-Q1, high on Q2-Q3; SDA changes only at Q0; SDA sampled at Q2.
REQ-015 States: IDLE, START, ADDR, REG, DATA, ACK, STOP, GAP, FINISH, FAIL.
REQ-016 IDLE: SCL=1, SDA released; start (or AUTO_START after reset) -> START, word index=0, busy=1, done=0, error=0.
REQ-017 START: SDA low with SCL high for 2 ticks, then SCL low -> ADDR.
REQ-018 Each of ADDR/REG/DATA SHALL shift 8 bits MSB first, then ACK state releases SDA for one bit and samples it.
REQ-019 Bytes per word: {DEV_ADDR,0}, word[15:8], word[7:0].
REQ-020 STOP: SDA low during SCL low, SCL high, then SDA released with SCL high; then GAP of 8 ticks (bus idle).
REQ-021 After GAP: index<NUM_REGS-1 -> index+1, START; index==NUM_REGS-1 -> FINISH.
REQ-022 FINISH: busy=0, done=1 (sticky until next start or reset), -> IDLE.
REQ-023 start while busy SHALL be ignored (not queued); start in same cycle as FINISH ignored.
REQ-024 Index counter SHALL never wrap past NUM_REGS-1; NUM_REGS=1 sends exactly one word.
REQ-025 Total SCL pulses per word SHALL be exactly 27 (3x9).

Reset
REQ-026 reset SHALL, in the cycle it is sampled high, including mid-transfer: state=IDLE, SCL=1, SDA released, busy=0, done=0, error=0, err_index=0, divider=0, retry count=0.
REQ-027 Reset mid-byte SHALL NOT generate a STOP condition; the slave recovers on the next START.

Configuration
REQ-028 Macro I2C_ACK_CHECK_EN defined: SDA=1 at an ACK sample = NACK -> STOP, GAP, retry same word from START; after MAX_RETRY failed retries -> FAIL: busy=0, error=1, err_index=index, done=0, -> IDLE.
REQ-029 Macro I2C_ACK_CHECK_EN undefined: ACK samples ignored, error and err_index tied 0, sequence always completes.

Verification
REQ-030 CLK_DIV=4, NUM_REGS=2, AUTO_START=0, slave model ACKs; start pulse -> 2 frames 0x34 0x0C 0x17, 0x34 0x12 0x01 decoded; done=1 after both; 54 SCL pulses total.
REQ-031 AUTO_START=1, reset released -> busy=1 next cycle, first SDA fall while SCL=1 within CLK_DIV+1 cycles.
REQ-032 ACK_CHECK_EN, slave NACKs word 1 data byte always -> 4 frames of word 1 (1+3 retries), error=1, err_index=1, done=0.
REQ-033 ACK_CHECK_EN, slave NACKs word 0 once -> word 0 resent once, done=1, error=0.
REQ-034 reset asserted during REG byte bit 3 -> next cycle SCL=1, SDA=z, busy=0; new start -> full sequence from word 0.
REQ-035 start pulsed every 10 cycles during a sequence -> exactly one sequence; no extra frames.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Writes NUM_REGS 16-bit {reg_addr, data} words to one I2C slave, one START..STOP frame per word.
// Optional I2C_ACK_CHECK_EN: NACK triggers per-word retry up to MAX_RETRY, then FAIL with err_index.
module i2c_reg_sequencer #(
  parameter int          NUM_REGS   = 9,
  parameter int          CLK_DIV    = 125,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int          AUTO_START = 1,
  parameter int          MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_REGS*16-1:0] cfg_table,
  inout  wire                   i2c_data,
  output logic                  i2c_clk,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [5:0]            err_index
);
`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_REG, S_DATA, S_ACK, S_STOP, S_GAP, S_FINISH, S_FAIL
  } state_t;

  state_t      state, state_n;
  logic [DW-1:0] div, div_n;
  logic [1:0]  q, q_n, byte_sel, byte_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  sr, sr_n, retry, retry_n;
  logic [5:0]  idx, idx_n, err_idx_r, erri_n;
  logic        scl, scl_n, sda_low, sda_low_n, nack, nack_n;
  logic        busy_n, done_n, err_r, err_n, auto_pend, auto_n;
  logic        tick, sda_in;
  logic [15:0] words [2**IW];
  logic [15:0] cur_word;

  for (genvar k = 0; k < 2**IW; k++) begin : g_word
    if (k < NUM_REGS) begin : g_v
      assign words[k] = cfg_table[16*k +: 16];
    end else begin : g_z
      assign words[k] = 16'h0;
    end
  end

  assign cur_word  = words[idx[IW-1:0]];
  assign tick      = (div == DW'(CLK_DIV-1));
  assign sda_in    = i2c_data;
  assign i2c_data  = sda_low ? 1'b0 : 1'bz;
  assign i2c_clk   = scl;
  assign error     = ACK_CHK ? err_r : 1'b0;
  assign err_index = ACK_CHK ? err_idx_r : 6'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;  div <= '0;  q <= '0;  byte_sel <= '0;  bit_cnt <= '0;
      sr <= '0;  retry <= '0;  idx <= '0;  err_idx_r <= '0;
      scl <= 1'b1;  sda_low <= 1'b0;  nack <= 1'b0;
      busy <= 1'b0;  done <= 1'b0;  err_r <= 1'b0;  auto_pend <= (AUTO_START != 0);
    end else begin
      state <= state_n;  div <= div_n;  q <= q_n;  byte_sel <= byte_n;  bit_cnt <= bit_n;
      sr <= sr_n;  retry <= retry_n;  idx <= idx_n;  err_idx_r <= erri_n;
      scl <= scl_n;  sda_low <= sda_low_n;  nack <= nack_n;
      busy <= busy_n;  done <= done_n;  err_r <= err_n;  auto_pend <= auto_n;
    end
  end

  always_comb begin
    state_n = state;  div_n = '0;  q_n = q;  byte_n = byte_sel;  bit_n = bit_cnt;
    sr_n = sr;  retry_n = retry;  idx_n = idx;  erri_n = err_idx_r;
    scl_n = scl;  sda_low_n = sda_low;  nack_n = nack;
    busy_n = busy;  done_n = done;  err_n = err_r;  auto_n = auto_pend;
    if (state != S_IDLE && state != S_FINISH && state != S_FAIL)
      div_n = tick ? '0 : div + DW'(1);
    case (state)
      S_IDLE: begin
        scl_n = 1'b1;  sda_low_n = 1'b0;
        if (start || auto_pend) begin
          state_n = S_START;  idx_n = '0;  retry_n = '0;  q_n = '0;
          busy_n = 1'b1;  done_n = 1'b0;  err_n = 1'b0;  erri_n = '0;  auto_n = 1'b0;
        end
      end
      S_START: if (tick) begin
        if (q == 2'd0) begin
          sda_low_n = 1'b1;  q_n = 2'd1;
        end else begin
          q_n = 2'd0;  bit_n = 3'd7;  byte_n = 2'd0;  nack_n = 1'b0;
          sr_n = {DEV_ADDR, 1'b0};  state_n = S_ADDR;
        end
      end
      S_ADDR, S_REG, S_DATA: if (tick) begin
        q_n = q + 2'd1;
        case (q)
          2'd0: begin scl_n = 1'b0; sda_low_n = ~sr[7]; end
          2'd2: scl_n = 1'b1;
          2'd3: begin
            sr_n = {sr[6:0], 1'b0};
            if (bit_cnt == 3'd0) state_n = S_ACK;
            else bit_n = bit_cnt - 3'd1;
          end
          default: ;
        endcase
      end
      S_ACK: if (tick) begin
        q_n = q + 2'd1;
        case (q)
          2'd0: begin scl_n = 1'b0; sda_low_n = 1'b0; end
          2'd2: begin scl_n = 1'b1; if (ACK_CHK && sda_in) nack_n = 1'b1; end
          2'd3: begin
            bit_n = 3'd7;
            // A NACK on any byte abandons the frame with a proper STOP
            if (nack || byte_sel == 2'd2) state_n = S_STOP;
            else if (byte_sel == 2'd0) begin
              sr_n = cur_word[15:8];  byte_n = 2'd1;  state_n = S_REG;
            end else begin
              sr_n = cur_word[7:0];   byte_n = 2'd2;  state_n = S_DATA;
            end
          end
          default: ;
        endcase
      end
      S_STOP: if (tick) begin
        q_n = q + 2'd1;
        case (q)
          2'd0: begin scl_n = 1'b0; sda_low_n = 1'b1; end
          2'd2: scl_n = 1'b1;
          2'd3: begin sda_low_n = 1'b0; bit_n = 3'd7; state_n = S_GAP; end
          default: ;
        endcase
      end
      S_GAP: if (tick) begin
        if (bit_cnt != 3'd0) bit_n = bit_cnt - 3'd1;
        else if (nack) begin
          if (retry == 8'(MAX_RETRY)) state_n = S_FAIL;
          else begin retry_n = retry + 8'd1; q_n = '0; state_n = S_START; end
        end else begin
          retry_n = '0;  q_n = '0;
          if (idx == 6'(NUM_REGS-1)) state_n = S_FINISH;
          else begin idx_n = idx + 6'd1; state_n = S_START; end
        end
      end
      S_FINISH: begin busy_n = 1'b0; done_n = 1'b1; state_n = S_IDLE; end
      S_FAIL: begin
        busy_n = 1'b0;  err_n = 1'b1;  erri_n = idx;  done_n = 1'b0;  state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
